booth_mac_accumulator: RTL and testbench

Downstream stage of the 4-bit Booth multiplier. It consumes the multiplier's sign-magnitude product (8-bit magnitude plus sign flag) and rebuilds the two's-complement value. It accumulates N_TERMS products into a saturating signed accumulator, forming a small dot-product/MAC unit. The finished sum is presented on a valid/ready output handshake, and the block then re-arms for the next frame.

---
 rtl/booth_mac_accumulator_if.sv | 27 ++
 rtl/booth_mac_accumulator.sv | 128 ++++++++++++
 tb/tb_booth_mac_accumulator.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_mac_accumulator_if.sv
// Beat-in / frame-result-out bundle for the Booth MAC accumulator.
// The producer/consumer side uses master; the accumulator uses slave.
interface booth_mac_accumulator_if #(
   parameter int ACC_W = 12,
   parameter int CNT_W = 3
);
   logic [7:0]              prod;
   logic                    sign;
   logic                    in_valid;
   logic                    in_ready;
   logic                    clear;
   logic signed [ACC_W-1:0] result;
   logic                    out_valid;
   logic                    out_ready;
   logic                    ovf;
   logic [CNT_W-1:0]        term_cnt;

   modport master (
      output prod, sign, in_valid, clear, out_ready,
      input  in_ready, result, out_valid, ovf, term_cnt
   );

   modport slave (
      input  prod, sign, in_valid, clear, out_ready,
      output in_ready, result, out_valid, ovf, term_cnt
   );
endinterface

// File: rtl/booth_mac_accumulator.sv
// Saturating MAC that folds N_TERMS sign-magnitude Booth products into one
// signed frame sum and hands it off over a valid/ready port.
module booth_mac_accumulator #(
   parameter int ACC_W   = 12,
   parameter int N_TERMS = 4,
   parameter int CNT_W   = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   booth_mac_accumulator_if.slave bus
);

   // Two guard bits beyond ACC_W keep acc + val from wrapping even at the
   // narrowest accumulator widths, so the clamp always sees the true sum.
   localparam int SW = ACC_W + 2;
   localparam logic signed [SW-1:0] ACC_MAX = SW'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [SW-1:0] ACC_MIN = SW'(-(2 ** (ACC_W - 1)));
   localparam logic [CNT_W-1:0]     LAST    = CNT_W'(N_TERMS - 1);

   typedef enum logic {
      S_ACC  = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   function automatic logic signed [SW-1:0] to_twos(input logic [7:0] mag,
                                                    input logic       neg);
      logic signed [SW-1:0] ext;
      ext = $signed({{(SW - 8){1'b0}}, mag});
      return neg ? -ext : ext;
   endfunction

   function automatic logic signed [ACC_W-1:0] saturate(input logic signed [SW-1:0] s);
      if (s > ACC_MAX)
         return $signed(ACC_MAX[ACC_W-1:0]);
      else if (s < ACC_MIN)
         return $signed(ACC_MIN[ACC_W-1:0]);
      else
         return $signed(s[ACC_W-1:0]);
   endfunction

   function automatic logic out_of_range(input logic signed [SW-1:0] s);
      return (s > ACC_MAX) || (s < ACC_MIN);
   endfunction

   state_t                  state_p0;
   state_t                  state_nxt;
   logic signed [ACC_W-1:0] acc_p0;
   logic signed [ACC_W-1:0] result_p1;
   logic                    ovf_p0;
   logic [CNT_W-1:0]        cnt_p0;
   logic                    vld_p1;

   logic signed [SW-1:0]    val_c;
   logic signed [SW-1:0]    acc_ext_c;
   logic signed [SW-1:0]    sum_c;
   logic signed [ACC_W-1:0] sat_c;
   logic                    beat_ovf_c;
   logic                    accept;
   logic                    last_beat;
   logic                    handoff;

   // Stage 0: operand rebuild, add and per-beat clamp
   always_comb begin
      val_c      = to_twos(bus.prod, bus.sign);
      acc_ext_c  = $signed({{2{acc_p0[ACC_W-1]}}, acc_p0});
      sum_c      = acc_ext_c + val_c;
      sat_c      = saturate(sum_c);
      beat_ovf_c = out_of_range(sum_c);
   end

   assign bus.in_ready = (state_p0 == S_ACC) && !rst;
   assign accept       = bus.in_valid && bus.in_ready && !bus.clear;
   assign last_beat    = accept && (cnt_p0 == LAST);
   assign handoff      = (state_p0 == S_HOLD) && bus.out_ready && !bus.clear;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_p0 <= S_ACC;
      else
         state_p0 <= state_nxt;
   end

   always_comb begin
      state_nxt = state_p0;
      if (bus.clear) begin
         state_nxt = S_ACC;
      end else begin
         case (state_p0)
            S_ACC:   if (last_beat) state_nxt = S_HOLD;
            S_HOLD:  if (handoff)   state_nxt = S_ACC;
            default: state_nxt = S_ACC;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_p0    <= '0;
         cnt_p0    <= '0;
         ovf_p0    <= 1'b0;
         result_p1 <= '0;
      end else if (bus.clear) begin
         acc_p0 <= '0;
         cnt_p0 <= '0;
         ovf_p0 <= 1'b0;
      end else if (accept) begin
         ovf_p0 <= ovf_p0 | beat_ovf_c;
         if (last_beat) begin
            acc_p0    <= '0;
            cnt_p0    <= '0;
            result_p1 <= sat_c;
         end else begin
            acc_p0 <= sat_c;
            cnt_p0 <= cnt_p0 + CNT_W'(1);
         end
      end else if (handoff) begin
         ovf_p0 <= 1'b0;
      end
   end

   // Stage 1: frame result presented while the FSM sits in HOLD
   assign vld_p1        = (state_p0 == S_HOLD);
   assign bus.out_valid = vld_p1;
   assign bus.result    = result_p1;
   assign bus.ovf       = ovf_p0;
   assign bus.term_cnt  = cnt_p0;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Bench for booth_mac_accumulator: frame table plus scoreboard on the default
// instance, hand-written corner sequences on both default and 8-bit instances.
module tb_booth_mac_accumulator;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   booth_mac_accumulator_if #(.ACC_W(12), .CNT_W(3)) bus_a ();
   booth_mac_accumulator_if #(.ACC_W(8),  .CNT_W(3)) bus_b ();

   booth_mac_accumulator #(.ACC_W(12), .N_TERMS(4), .CNT_W(3)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   booth_mac_accumulator #(.ACC_W(8), .N_TERMS(4), .CNT_W(3)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   typedef struct {
      int p[4];
      int s[4];
      int res;
      int ovf;
   } frame_t;

   typedef struct {
      int res;
      int ovf;
   } exp_t;

   exp_t   sb[$];
   frame_t tbl[6];
   int     tests = 0;
   int     fails = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every result handshake on the default instance pops one entry
   always @(negedge clk) begin
      if (!rst && bus_a.out_valid && bus_a.out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: result %0d with no expected entry", bus_a.result);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_result", int'(bus_a.result), e.res);
            check("sb_ovf", int'(bus_a.ovf), e.ovf);
         end
      end
   end

   task automatic send_a(input logic [7:0] p, input logic s);
      int   n;
      logic took;
      n = 0;
      took = 1'b0;
      bus_a.prod = p;
      bus_a.sign = s;
      bus_a.in_valid = 1'b1;
      do begin
         @(negedge clk);
         took = bus_a.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 50);
      bus_a.in_valid = 1'b0;
      if (!took) begin
         tests++;
         fails++;
         $display("FAIL send_a_timeout: in_ready stayed 0 for %0d cycles", n);
      end
   endtask

   task automatic send_b(input logic [7:0] p, input logic s);
      int   n;
      logic took;
      n = 0;
      took = 1'b0;
      bus_b.prod = p;
      bus_b.sign = s;
      bus_b.in_valid = 1'b1;
      do begin
         @(negedge clk);
         took = bus_b.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 50);
      bus_b.in_valid = 1'b0;
      if (!took) begin
         tests++;
         fails++;
         $display("FAIL send_b_timeout: in_ready stayed 0 for %0d cycles", n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{'{6, 15, 64, 0},     '{0, 1, 0, 1}, 55,    0};
      tbl[1] = '{'{0, 0, 0, 0},       '{1, 1, 1, 1}, 0,     0};
      tbl[2] = '{'{255, 255, 255, 255}, '{0, 0, 0, 0}, 1020,  0};
      tbl[3] = '{'{255, 255, 255, 255}, '{1, 1, 1, 1}, -1020, 0};
      tbl[4] = '{'{128, 1, 200, 73},  '{1, 0, 0, 1}, 0,     0};
      tbl[5] = '{'{100, 50, 7, 7},    '{0, 1, 0, 1}, 50,    0};

      rst = 1'b1;
      bus_a.prod = '0; bus_a.sign = 1'b0; bus_a.in_valid = 1'b0;
      bus_a.clear = 1'b0; bus_a.out_ready = 1'b0;
      bus_b.prod = '0; bus_b.sign = 1'b0; bus_b.in_valid = 1'b0;
      bus_b.clear = 1'b0; bus_b.out_ready = 1'b0;

      #2;
      check("rst_in_ready", int'(bus_a.in_ready), 0);
      check("rst_out_valid", int'(bus_a.out_valid), 0);
      check("rst_result", int'(bus_a.result), 0);
      check("rst_ovf", int'(bus_a.ovf), 0);
      check("rst_term_cnt", int'(bus_a.term_cnt), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", int'(bus_a.in_ready), 1);

      // Basic frame with latency and re-arm timing
      bus_a.out_ready = 1'b1;
      sb.push_back('{55, 0});
      send_a(8'd6, 1'b0);
      send_a(8'd15, 1'b1);
      send_a(8'd64, 1'b0);
      send_a(8'd0, 1'b1);
      check("t1_out_valid", int'(bus_a.out_valid), 1);
      check("t1_result", int'(bus_a.result), 55);
      check("t1_in_ready_hold", int'(bus_a.in_ready), 0);
      @(posedge clk);
      #1;
      check("t1_out_valid_drop", int'(bus_a.out_valid), 0);
      check("t1_in_ready_rearm", int'(bus_a.in_ready), 1);

      // Frame table through the scoreboard
      for (int i = 0; i < 6; i++) begin
         sb.push_back('{tbl[i].res, tbl[i].ovf});
         for (int j = 0; j < 4; j++)
            send_a(8'(tbl[i].p[j]), 1'(tbl[i].s[j]));
         @(posedge clk);
         #1;
      end

      // Back-pressure: result held, incoming beats refused
      bus_a.out_ready = 1'b0;
      sb.push_back('{-256, 0});
      for (int j = 0; j < 4; j++) send_a(8'd64, 1'b1);
      bus_a.prod = 8'd5;
      bus_a.sign = 1'b0;
      bus_a.in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t2_hold_valid", int'(bus_a.out_valid), 1);
         check("t2_hold_in_ready", int'(bus_a.in_ready), 0);
         check("t2_hold_result", int'(bus_a.result), -256);
         check("t2_hold_term_cnt", int'(bus_a.term_cnt), 0);
         @(posedge clk);
         #1;
      end
      bus_a.in_valid = 1'b0;
      bus_a.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t2_after_hs_valid", int'(bus_a.out_valid), 0);
      check("t2_after_hs_in_ready", int'(bus_a.in_ready), 1);
      check("t2_after_hs_term_cnt", int'(bus_a.term_cnt), 0);
      sb.push_back('{10, 0});
      for (int j = 1; j <= 4; j++) send_a(8'(j), 1'b0);
      @(posedge clk);
      #1;

      // 8-bit accumulator: per-beat saturation makes the result order-dependent
      send_b(8'd100, 1'b0);
      check("t3_ovf_beat1", int'(bus_b.ovf), 0);
      send_b(8'd100, 1'b0);
      check("t3_ovf_beat2", int'(bus_b.ovf), 1);
      check("t3_cnt_beat2", int'(bus_b.term_cnt), 2);
      send_b(8'd64, 1'b1);
      check("t3_ovf_beat3", int'(bus_b.ovf), 1);
      check("t3_cnt_beat3", int'(bus_b.term_cnt), 3);
      send_b(8'd64, 1'b1);
      check("t3_out_valid", int'(bus_b.out_valid), 1);
      check("t3_result", int'(bus_b.result), -1);
      check("t3_ovf_final", int'(bus_b.ovf), 1);
      @(posedge clk);
      #1;
      check("t3_result_held", int'(bus_b.result), -1);
      check("t3_ovf_held", int'(bus_b.ovf), 1);
      bus_b.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus_b.out_ready = 1'b0;
      check("t3_valid_after_hs", int'(bus_b.out_valid), 0);
      check("t3_ovf_after_hs", int'(bus_b.ovf), 0);
      check("t3_in_ready_after_hs", int'(bus_b.in_ready), 1);

      // Clear mid-frame with a concurrent beat
      send_a(8'd10, 1'b0);
      send_a(8'd20, 1'b0);
      check("t5_cnt_before_clear", int'(bus_a.term_cnt), 2);
      bus_a.clear = 1'b1;
      bus_a.prod = 8'd99;
      bus_a.sign = 1'b0;
      bus_a.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus_a.clear = 1'b0;
      bus_a.in_valid = 1'b0;
      check("t5_cnt_after_clear", int'(bus_a.term_cnt), 0);
      check("t5_ovf_after_clear", int'(bus_a.ovf), 0);
      sb.push_back('{4, 0});
      for (int j = 0; j < 4; j++) send_a(8'd1, 1'b0);
      @(posedge clk);
      #1;

      // Asynchronous reset landing mid-HOLD, away from both clock edges
      bus_a.out_ready = 1'b0;
      for (int j = 0; j < 4; j++) send_a(8'd50, 1'b0);
      check("t6_hold_valid", int'(bus_a.out_valid), 1);
      check("t6_hold_result", int'(bus_a.result), 200);
      #2;
      rst = 1'b1;
      #1;
      check("t6_rst_out_valid", int'(bus_a.out_valid), 0);
      check("t6_rst_result", int'(bus_a.result), 0);
      check("t6_rst_ovf", int'(bus_a.ovf), 0);
      check("t6_rst_term_cnt", int'(bus_a.term_cnt), 0);
      check("t6_rst_in_ready", int'(bus_a.in_ready), 0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus_a.out_ready = 1'b1;
      sb.push_back('{12, 0});
      for (int j = 0; j < 4; j++) send_a(8'd3, 1'b0);
      check("t6_fresh_result", int'(bus_a.result), 12);
      @(posedge clk);
      #1;

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
